// File: rtl/led_pwm_lbus.sv
// Local-bus LED slave: four active-low LEDs with 8-bit PWM brightness and blink gating.
// Latency: register writes land on the write edge; led_n is registered one cycle after the on condition.
// Backpressure: none; every write is accepted in one cycle, and readback is combinational.

package led_pwm_lbus_pkg;
    // Slave view of the local bus. The decode in front of this slave qualifies we
    // and hands over only the word offset inside its 4-word window.
    typedef struct packed {
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        we;
    } lb_slave_t;
endpackage

module led_pwm_lbus
    import led_pwm_lbus_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PWM_BITS = 8
) (
    input  logic              lb_clk,
    input  logic              rst_n,
    input  lb_slave_t         xt_lb,
    output logic [15:0]       rdata,
    output logic [NUM_CH-1:0] led_n
);

    // Software-visible (shadow) registers
    logic [PWM_BITS-1:0] r_duty_sh [NUM_CH];
    logic [15:0]         r_prescale;
    logic [15:0]         r_ctrl;

    // Running state
    logic [15:0]         r_pre_cnt;
    logic [PWM_BITS-1:0] r_phase;
    logic [PWM_BITS-1:0] r_duty_act [NUM_CH];
    logic [7:0]          r_blk_cnt;
    logic                r_blink_phase;
    logic [NUM_CH-1:0]   r_led_n;

    logic                w_wr_duty01;
    logic                w_wr_duty23;
    logic                w_wr_pre;
    logic                w_wr_ctrl;
    logic                w_tick;
    logic                w_wrap;
    logic [NUM_CH-1:0]   w_en;
    logic [NUM_CH-1:0]   w_mask;
    logic [7:0]          w_period;
    logic                w_blink_on;
    logic [NUM_CH-1:0]   w_on;

    assign w_wr_duty01 = xt_lb.we && (xt_lb.addr == 2'd0);
    assign w_wr_duty23 = xt_lb.we && (xt_lb.addr == 2'd1);
    assign w_wr_pre    = xt_lb.we && (xt_lb.addr == 2'd2);
    assign w_wr_ctrl   = xt_lb.we && (xt_lb.addr == 2'd3);

    assign w_en     = r_ctrl[3:0];
    assign w_mask   = r_ctrl[7:4];
    assign w_period = r_ctrl[15:8];

    // A PRESCALE write restarts the counters, so it must not also count as a tick/wrap.
    assign w_tick = (r_pre_cnt == r_prescale) && !w_wr_pre;
    assign w_wrap = w_tick && (r_phase == '1);

    // Period 0 means "no blinking": treat blink as always lit, also in the cycle
    // right after the CTRL write before the registered phase is forced.
    assign w_blink_on = r_blink_phase || (w_period == 8'd0);

    // Shadow register writes from the local bus
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
            r_prescale <= '0;
            r_ctrl     <= '0;
        end else begin
            if (w_wr_duty01) begin
                r_duty_sh[0] <= xt_lb.wdata[7:0];
                r_duty_sh[1] <= xt_lb.wdata[15:8];
            end
            if (w_wr_duty23) begin
                r_duty_sh[2] <= xt_lb.wdata[7:0];
                r_duty_sh[3] <= xt_lb.wdata[15:8];
            end
            if (w_wr_pre)  r_prescale <= xt_lb.wdata;
            if (w_wr_ctrl) r_ctrl     <= xt_lb.wdata;
        end
    end

    // Prescaler and PWM phase counter; a PRESCALE write restarts both from zero
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_phase   <= '0;
        end else if (w_wr_pre) begin
            r_pre_cnt <= '0;
            r_phase   <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_phase   <= r_phase + 1'b1;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

    // Active duties reload only at the period boundary so a pulse is never cut short;
    // a write on the same edge is seen at the following wrap (NBA gives the old shadow)
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= '0;
        end else if (w_wrap) begin
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty_sh[i];
        end
    end

    // Blink divider counts PWM periods and toggles the blink phase every 'period' wraps
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt     <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_period == 8'd0) begin
            r_blk_cnt     <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_blk_cnt     <= '0;
        end else if (w_wrap) begin
            if (r_blk_cnt == (w_period - 8'd1)) begin
                r_blk_cnt     <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blk_cnt     <= r_blk_cnt + 8'd1;
            end
        end
    end

    // Per-channel on condition: enabled, inside the duty window, and not blanked by blink
    always_comb begin
        w_on = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_on[i] = w_en[i] && (r_phase < r_duty_act[i]) && (!w_mask[i] || w_blink_on);
        end
    end

    // Registered active-low LED drive, all off in reset
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_n <= '1;
        end else begin
            r_led_n <= ~w_on;
        end
    end

    assign led_n = r_led_n;

    // Combinational readback of the shadow registers
    always_comb begin
        rdata = '0;
        case (xt_lb.addr)
            2'd0:    rdata = {r_duty_sh[1], r_duty_sh[0]};
            2'd1:    rdata = {r_duty_sh[3], r_duty_sh[2]};
            2'd2:    rdata = r_prescale;
            default: rdata = r_ctrl;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_lbus.sv
module tb_led_pwm_lbus;
    import led_pwm_lbus_pkg::*;

    logic        lb_clk;
    logic        rst_n;
    lb_slave_t   xt_lb;
    logic [15:0] rdata;
    logic [3:0]  led_n;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q [$];

    led_pwm_lbus #(.NUM_CH(4), .PWM_BITS(8)) dut (
        .lb_clk (lb_clk),
        .rst_n  (rst_n),
        .xt_lb  (xt_lb),
        .rdata  (rdata),
        .led_n  (led_n)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    // Pop the expected value queued with the stimulus and compare
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic lb_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge lb_clk);
        xt_lb.addr  = a;
        xt_lb.wdata = d;
        xt_lb.we    = 1'b1;
        @(negedge lb_clk);
        xt_lb.we    = 1'b0;
    endtask

    task automatic lb_read_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
        xt_lb.addr = a;
        exp_q.push_back({16'h0, exp});
        #1;
        check(tag, {16'h0, rdata});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge lb_clk);
    endtask

    // Count low (lit) samples per channel over n cycles
    task automatic count_low(input int n, output int c0, output int c1, output int c2, output int c3);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge lb_clk);
            if (!led_n[0]) c0++;
            if (!led_n[1]) c1++;
            if (!led_n[2]) c2++;
            if (!led_n[3]) c3++;
        end
    endtask

    // Lit count and longest dark run of ch0 over n cycles
    task automatic measure_ch0(input int n, output int lows, output int max_high);
        int run;
        lows = 0; max_high = 0; run = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge lb_clk);
            if (!led_n[0]) begin
                lows++;
                run = 0;
            end else begin
                run++;
                if (run > max_high) max_high = run;
            end
        end
    endtask

    // Stop at the first sample where ch0 turns on (start of a PWM period)
    task automatic sync_ch0_on(input int bound, output logic found);
        logic prev;
        found = 1'b0;
        prev = led_n[0];
        for (int k = 0; k < bound; k++) begin
            @(negedge lb_clk);
            if (prev && !led_n[0]) begin
                found = 1'b1;
                break;
            end
            prev = led_n[0];
        end
    endtask

    initial begin
        int c0, c1, c2, c3, lows, maxh, bad;
        logic found;

        rst_n = 1'b0;
        xt_lb = '0;
        wait_cycles(4);
        rst_n = 1'b1;

        // Reset state
        lb_read_check("rst_rd0", 2'd0, 16'h0000);
        lb_read_check("rst_rd1", 2'd1, 16'h0000);
        lb_read_check("rst_rd2", 2'd2, 16'h0000);
        lb_read_check("rst_rd3", 2'd3, 16'h0000);
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge lb_clk);
            if (led_n !== 4'hF) bad++;
        end
        exp_q.push_back(32'd0);
        check("rst_led_off_1000", bad);

        // Basic PWM, prescale 0
        lb_write(2'd2, 16'h0000);
        lb_write(2'd0, 16'h4080);
        lb_write(2'd3, 16'h0003);
        lb_read_check("rd_duty01", 2'd0, 16'h4080);
        lb_read_check("rd_ctrl", 2'd3, 16'h0003);
        wait_cycles(600);
        exp_q.push_back(32'd128);
        exp_q.push_back(32'd64);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        count_low(256, c0, c1, c2, c3);
        check("pwm_ch0_128", c0);
        check("pwm_ch1_64", c1);
        check("pwm_ch2_off", c2);
        check("pwm_ch3_off", c3);

        // Mid-period duty writes only take effect at the next wrap
        sync_ch0_on(600, found);
        exp_q.push_back(32'd1);
        check("sync_duty", {31'd0, found});
        lows = 1;
        for (int k = 1; k < 256; k++) begin
            @(negedge lb_clk);
            if (!led_n[0]) lows++;
            if (k == 40) begin
                xt_lb.addr = 2'd0; xt_lb.wdata = 16'h0000; xt_lb.we = 1'b1;
            end else if (k == 41) begin
                xt_lb.wdata = 16'h00FF;
            end else if (k == 42) begin
                xt_lb.we = 1'b0;
                lb_read_check("rd_duty_immediate", 2'd0, 16'h00FF);
            end
        end
        exp_q.push_back(32'd128);
        check("old_duty_until_wrap", lows);
        exp_q.push_back(32'd255);
        count_low(256, c0, c1, c2, c3);
        check("duty255_after_wrap", c0);

        // Prescale 3: 1024-cycle period, duty 16 -> 64 lit cycles
        lb_write(2'd0, 16'h0010);
        lb_write(2'd3, 16'h0001);
        lb_write(2'd2, 16'h0003);
        wait_cycles(2500);
        exp_q.push_back(32'd64);
        count_low(1024, c0, c1, c2, c3);
        check("pre3_lit_64", c0);
        sync_ch0_on(1200, found);
        exp_q.push_back(32'd1);
        check("sync_pre3", {31'd0, found});
        wait_cycles(100);
        lb_write(2'd2, 16'h0003);
        exp_q.push_back(32'd0);
        @(negedge lb_clk);
        check("pre_write_restart", {31'd0, led_n[0]});
        lows = 1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge lb_clk);
            if (led_n[0]) break;
            lows++;
        end
        exp_q.push_back(32'd64);
        check("pre_restart_run_64", lows);

        // Blink: period 2, mask ch0, duty 255
        lb_write(2'd2, 16'h0000);
        lb_write(2'd0, 16'h00FF);
        lb_write(2'd3, 16'h0211);
        wait_cycles(3000);
        exp_q.push_back(32'd1530);
        exp_q.push_back(32'd513);
        measure_ch0(3072, lows, maxh);
        check("blink_lit_count", lows);
        check("blink_dark_run", maxh);

        // Period 0 stops blinking
        lb_write(2'd3, 16'h0011);
        wait_cycles(600);
        exp_q.push_back(32'd255);
        count_low(256, c0, c1, c2, c3);
        check("blink_off_pwm", c0);
        exp_q.push_back(32'd0);
        count_low(256, c0, c1, c2, c3);
        check("blink_off_ch1", c1);

        // Asynchronous reset mid-period
        wait_cycles(37);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'hF);
        check("arst_led_off", {28'd0, led_n});
        lb_read_check("arst_rd0", 2'd0, 16'h0000);
        lb_read_check("arst_rd1", 2'd1, 16'h0000);
        lb_read_check("arst_rd2", 2'd2, 16'h0000);
        lb_read_check("arst_rd3", 2'd3, 16'h0000);
        wait_cycles(3);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge lb_clk);
            if (led_n !== 4'hF) bad++;
        end
        exp_q.push_back(32'd0);
        check("post_rst_off", bad);
        lb_read_check("post_rst_rd3", 2'd3, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "timeout");
    end

endmodule
